// File: rtl/pkg_instrucao.sv
// Shared field layout and opcode constants for the instruction word codec.
// Latency: none (declarations only).
// Backpressure: not applicable.
package pkg_instrucao;

  localparam int PALAVRA_W = 32;

  localparam int OPCODE_W  = 4;
  localparam int LINHA_W   = 3;
  localparam int COLUNA_W  = 3;
  localparam int DADO_W    = 16;
  localparam int ID_W      = 2;

  localparam int OPCODE_LSB   = 28;
  localparam int LINHA_LSB    = 25;
  localparam int COLUNA_LSB   = 22;
  localparam int DADO_LSB     = 6;
  localparam int ID_LSB       = 4;
  localparam int PARIDADE_BIT = 0;

  // Opcodes understood by decodificador_instrucao
  localparam logic [OPCODE_W-1:0] OP_NOP       = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_ESCREVER  = 4'h1;
  localparam logic [OPCODE_W-1:0] OP_LER       = 4'h2;
  localparam logic [OPCODE_W-1:0] OP_SOMAR     = 4'h3;
  localparam logic [OPCODE_W-1:0] OP_MULTIPLIC = 4'h4;
  localparam logic [OPCODE_W-1:0] OP_TRANSPOR  = 4'h5;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [LINHA_W-1:0]  linha;
    logic [COLUNA_W-1:0] coluna;
    logic [DADO_W-1:0]   dado;
    logic [ID_W-1:0]     id_matriz;
  } campos_t;

  // Places each field at its bit position; the low nibble is left zero.
  function automatic logic [PALAVRA_W-1:0] empacotar(input campos_t c);
    logic [PALAVRA_W-1:0] w;
    w = '0;
    w[OPCODE_LSB +: OPCODE_W] = c.opcode;
    w[LINHA_LSB  +: LINHA_W]  = c.linha;
    w[COLUNA_LSB +: COLUNA_W] = c.coluna;
    w[DADO_LSB   +: DADO_W]   = c.dado;
    w[ID_LSB     +: ID_W]     = c.id_matriz;
    return w;
  endfunction

endpackage

// File: rtl/fifo_instrucao.sv
// Circular buffer of encoded words with occupancy count and synchronous flush.
// Latency: a pushed word is visible at cabeca the cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty; flush wins over both.
module fifo_instrucao #(
  parameter int LARGURA      = 32,
  parameter int PROFUNDIDADE = 4,
  localparam int PTR_W       = $clog2(PROFUNDIDADE),
  localparam int NIVEL_W     = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               limpar,
  input  logic               push,
  input  logic               pop,
  input  logic [LARGURA-1:0] dado_in,
  output logic [LARGURA-1:0] cabeca,
  output logic [NIVEL_W-1:0] nivel,
  output logic               cheio,
  output logic               vazio
);

  logic [LARGURA-1:0] mem [PROFUNDIDADE];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               push_ok;
  logic               pop_ok;

  assign cheio   = (nivel == NIVEL_W'(PROFUNDIDADE));
  assign vazio   = (nivel == '0);
  assign push_ok = push && !cheio && !limpar;
  assign pop_ok  = pop && !vazio && !limpar;
  assign cabeca  = mem[rd_ptr];

  // Storage write; contents need no reset because nivel gates every read
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= dado_in;
  end

  // Pointers wrap naturally since the depth is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      nivel  <= '0;
    end else if (limpar) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      nivel  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   nivel <= nivel + NIVEL_W'(1);
        2'b01:   nivel <= nivel - NIVEL_W'(1);
        default: nivel <= nivel;
      endcase
    end
  end

endmodule

// File: rtl/codificador_instrucao.sv
// Packs instruction fields into a 32-bit word and buffers it; CODIFICADOR_PARIDADE_EN adds even parity in bit 0.
// Latency: one cycle from accepted field set to instrucao on an empty FIFO.
// Backpressure: in_ready drops when full or flushing; instrucao holds until out_ready pops it.
module codificador_instrucao
  import pkg_instrucao::*;
#(
  parameter int PROFUNDIDADE = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           limpar,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [OPCODE_W-1:0]            opcode,
  input  logic [LINHA_W-1:0]             linha,
  input  logic [COLUNA_W-1:0]            coluna,
  input  logic [DADO_W-1:0]              dado,
  input  logic [ID_W-1:0]                id_matriz,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [PALAVRA_W-1:0]           instrucao,
  output logic [$clog2(PROFUNDIDADE):0]  nivel
);

  campos_t              campos;
  logic [PALAVRA_W-1:0] palavra;
  logic [PALAVRA_W-1:0] cabeca;
  logic                 cheio;
  logic                 vazio;
  logic                 ativo;
  logic                 push;
  logic                 pop;

  assign campos = '{opcode: opcode, linha: linha, coluna: coluna,
                    dado: dado, id_matriz: id_matriz};

  // Field packing, with parity folded in before the word is stored
  always_comb begin
    palavra = empacotar(campos);
`ifdef CODIFICADOR_PARIDADE_EN
    palavra[PARIDADE_BIT] = ^palavra[PALAVRA_W-1:1];
`endif
  end

  // Keeps in_ready low while reset is held and until the first edge after release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ativo <= 1'b0;
    else     ativo <= 1'b1;
  end

  assign in_ready  = ativo && !cheio && !limpar;
  assign out_valid = !vazio;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign instrucao = out_valid ? cabeca : '0;

  fifo_instrucao #(
    .LARGURA      (PALAVRA_W),
    .PROFUNDIDADE (PROFUNDIDADE)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .limpar  (limpar),
    .push    (push),
    .pop     (pop),
    .dado_in (palavra),
    .cabeca  (cabeca),
    .nivel   (nivel),
    .cheio   (cheio),
    .vazio   (vazio)
  );

endmodule
